// File: rtl/mem_line_arbiter.sv
`default_nettype none
// mem_line_arbiter -- round-robin two-port cache-line arbiter and 8-word SDRAM burst sequencer (rev 1.0).
// Optional burst watchdog enabled by defining MEM_LINE_ARB_TIMEOUT_EN.
module mem_line_arbiter #(
    parameter int TIMEOUT   = 128,
    parameter int BURST_LEN = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      p0_req,
    input  logic                      p0_we,
    input  logic [31:0]               p0_addr,
    input  logic [16*BURST_LEN-1:0]   p0_wdata,
    output logic [16*BURST_LEN-1:0]   p0_rdata,
    output logic                      p0_done,
    output logic                      p0_err,
    input  logic                      p1_req,
    input  logic                      p1_we,
    input  logic [31:0]               p1_addr,
    input  logic [16*BURST_LEN-1:0]   p1_wdata,
    output logic [16*BURST_LEN-1:0]   p1_rdata,
    output logic                      p1_done,
    output logic                      p1_err,
    output logic                      busy,
    output logic                      sdram_rd_req,
    output logic                      sdram_wr_req,
    output logic [23:0]               sdram_addr,
    input  logic                      sdram_ack,
    output logic [15:0]               sdram_wdata,
    input  logic                      sdram_wr_strobe,
    input  logic [15:0]               sdram_rdata,
    input  logic                      sdram_rd_valid
);

    localparam int LINE_W = 16 * BURST_LEN;
    localparam int IW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WR_BURST = 3'd2,
        RD_BURST = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                grant;
    logic                grant_next;
    logic                we_q;
    logic                err_q;
    logic                last_served;
    logic [IW-1:0]       idx;
    logic [LINE_W-1:0]   line_buf;
    logic [LINE_W-1:0]   line_next;
    logic [23:0]         addr_q;
    logic                active;
    logic                timeout;
    logic                finish_ok;
    logic                finish_to;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{p0_addr[31:25], p0_addr[3:0], p1_addr[31:25], p1_addr[3:0]};

    // When both ports are pending the one not served last wins.
    assign grant_next = (p0_req && p1_req) ? ~last_served : p1_req;
    assign active     = (state == REQ) || (state == WR_BURST) || (state == RD_BURST);
    assign finish_ok  = ((state == WR_BURST) && sdram_wr_strobe && (idx == LAST_IDX)) ||
                        ((state == RD_BURST) && sdram_rd_valid  && (idx == LAST_IDX));
    assign finish_to  = active && timeout && !finish_ok;

`ifdef MEM_LINE_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (active) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    assign timeout = (tmo_cnt == CW'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_comb begin
        line_next = line_buf;
        line_next[LINE_W-1-16*int'(idx) -: 16] = sdram_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (p0_req || p1_req) state_next = REQ;
            REQ: begin
                if (finish_to)      state_next = DONE;
                else if (sdram_ack) state_next = we_q ? WR_BURST : RD_BURST;
            end
            WR_BURST: if (finish_ok || finish_to) state_next = DONE;
            RD_BURST: if (finish_ok || finish_to) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        sdram_rd_req = (state == REQ) && !we_q;
        sdram_wr_req = (state == REQ) && we_q;
        sdram_addr   = addr_q;
        sdram_wdata  = '0;
        if (state == WR_BURST) sdram_wdata = line_buf[LINE_W-1-16*int'(idx) -: 16];
        p0_done      = (state == DONE) && !grant;
        p1_done      = (state == DONE) && grant;
        p0_err       = p0_done && err_q;
        p1_err       = p1_done && err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            last_served <= 1'b0;
            idx         <= '0;
            addr_q      <= '0;
            line_buf    <= '0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        grant    <= grant_next;
                        we_q     <= grant_next ? p1_we : p0_we;
                        addr_q   <= grant_next ? {p1_addr[24:4], 3'b000} : {p0_addr[24:4], 3'b000};
                        line_buf <= grant_next ? p1_wdata : p0_wdata;
                        idx      <= '0;
                        err_q    <= 1'b0;
                    end
                end
                REQ: begin
                    idx   <= '0;
                    err_q <= finish_to;
                end
                WR_BURST: begin
                    err_q <= finish_to;
                    if (sdram_wr_strobe) idx <= idx + IW'(1);
                end
                RD_BURST: begin
                    err_q <= finish_to;
                    if (sdram_rd_valid) begin
                        line_buf <= line_next;
                        idx      <= idx + IW'(1);
                        // Publish the completed line together with the done pulse.
                        if (idx == LAST_IDX) begin
                            if (grant) p1_rdata <= line_next;
                            else       p0_rdata <= line_next;
                        end
                    end
                end
                DONE: begin
                    last_served <= grant;
                    idx         <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Two-port cache-line arbiter and burst sequencer between the I-cache/D-cache miss handlers and the 16-bit SDRAM controller. Accepts 128-bit line read (refill) or write (write-back) requests, grants one requester at a time round-robin, and serialises each line into one aligned 8-word SDRAM burst. Optional watchdog aborts bursts that exceed MEM_ACCESS_TIMEOUT (128 cycles).

## Interface
- Parameters:
- TIMEOUT, default 128 (MEM_ACCESS_TIMEOUT): cycle budget per transaction.
- BURST_LEN, default 8 (sdram_access_len): 16-bit words per line.
- Ports (N = 0 I-cache, N = 1 D-cache):
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pN_req  in  1  level request; held until pN_done.
- pN_we  in  1  1 = write line to SDRAM, 0 = read line; stable while pN_req.
- pN_addr  in  32  byte address; bits [3:0] ignored.
- pN_wdata  in  128  write line; stable while pN_req.
- pN_rdata  out  128  last successfully read line for port N.
- pN_done  out  1  one-cycle completion pulse.
- pN_err  out  1  valid with pN_done; 1 = timed out.
- busy  out  1  high in any state other than IDLE.
- sdram_rd_req / sdram_wr_req  out  1  burst request.
- sdram_addr  out  24  word address = {addr[24:4], 3'b000}.
- sdram_ack  in  1  request accepted this cycle.
- sdram_wdata  out  16  current write word.
- sdram_wr_strobe  in  1  controller consumes sdram_wdata this cycle.
- sdram_rdata  in  16  read word.
- sdram_rd_valid  in  1  sdram_rdata valid this cycle.

## Operation
- FSM: IDLE -> REQ -> WR_BURST | RD_BURST -> DONE -> IDLE.
- IDLE: if any pN_req, latch winner's index, we, addr, wdata; go REQ.
- Arbitration: only one pending -> grant it; both pending -> grant the port not served last. After reset "last served" = port 0, so D-cache wins the first tie.
- REQ: assert sdram_rd_req or sdram_wr_req (per we) with sdram_addr; on sdram_ack drop request next cycle, go WR_BURST/RD_BURST, word index = 0.
- Word order: word k = line[127-16k -: 16] (k = 0 is MSB half of data word 0).
- WR_BURST: sdram_wdata = word[index] combinationally; each sdram_wr_strobe increments index; strobe at index 7 -> DONE.
- RD_BURST: each sdram_rd_valid writes sdram_rdata into line buffer word[index], index++; at index 7 -> DONE.
- DONE: pulse pN_done for granted port only; on success copy line buffer to pN_rdata (reads only); update last-served; go IDLE.
- Strobes/valids outside the matching burst state are ignored.
- Requester must drop pN_req the cycle after pN_done; a req still high in IDLE starts a new transaction.

## Timing
- Reset: state IDLE, all outputs 0 (pN_rdata = 0, sdram_addr = 0), last-served = 0, index = 0.
- Reset asserted mid-burst: immediate return to IDLE, no done pulse, rdata cleared.
- Minimum read latency: req seen cycle 0, REQ+ack cycle 1, rd_valid cycles 2-9, pN_done cycle 10; pN_rdata valid same cycle as done and held until that port's next successful read.
- Writes same shape: done one cycle after the 8th strobe.
- Back-to-back: new grant earliest one cycle after DONE (IDLE cycle).
- Gaps between strobes/valids unbounded (subject to timeout).

## Configuration
- MEM_LINE_ARB_TIMEOUT_EN defined: 7-bit cycle counter cleared on entry to REQ, counts every cycle in REQ/WR_BURST/RD_BURST; reaching TIMEOUT cycles without completion forces DONE with pN_err = 1, pN_rdata unchanged, sdram requests dropped.
- Not defined: no counter; FSM waits indefinitely; pN_err tied to 0.

## Test plan
- Port 1 read addr 0x0000_1230, SDRAM returns 0x0001..0x0008 after ack -> sdram_addr 0x000918, p1_done at cycle 10, p1_rdata = 0x00010002...0007_0008, p1_err 0.
- Port 0 write 0xAAAA_BBBB_..._1111 (8 halves), strobes with 2-cycle gaps -> sdram_wdata sequence MSB half first, p0_done one cycle after 8th strobe.
- Both req same cycle after reset -> port 1 served first, port 0 next; repeat tie -> alternates 1,0,1,0.
- TIMEOUT_EN, only 3 rd_valid then silence -> p0_done with p0_err = 1 128 cycles after REQ entry, p0_rdata keeps previous value; without macro -> no done, busy stays 1.
- rst_n low during RD_BURST index 4 -> all outputs 0 asynchronously, no done; post-reset read completes normally.
- Spurious sdram_rd_valid in IDLE/WR_BURST -> no buffer or index change.
